// File: rtl/regfile_n_if.sv
// Bus bundle for regfile_n: write port, two read ports and entry flags.
// The master drives requests; the slave (register file) drives read results.
interface regfile_n_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
);
  logic             ClrAll;
  logic             WrEn;
  logic [AW-1:0]    WrAddr;
  logic [WIDTH-1:0] WrData;
  logic [AW-1:0]    RdAddrA;
  logic [WIDTH-1:0] RdDataA;
  logic             RdValidA;
  logic [AW-1:0]    RdAddrB;
  logic [WIDTH-1:0] RdDataB;
  logic             RdValidB;
  logic [DEPTH-1:0] Valid;

  modport master (
    output ClrAll, WrEn, WrAddr, WrData,
    output RdAddrA, RdAddrB,
    input  RdDataA, RdValidA,
    input  RdDataB, RdValidB,
    input  Valid
  );

  modport slave (
    input  ClrAll, WrEn, WrAddr, WrData,
    input  RdAddrA, RdAddrB,
    output RdDataA, RdValidA,
    output RdDataB, RdValidB,
    output Valid
  );
endinterface

// File: rtl/regfile_n.sv
// regfile_n: DEPTH x WIDTH register file, 1 write / 2 registered reads.
// Optional macro REGFILE_N_BYPASS_EN forwards same-cycle write data to reads.
module regfile_n #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        Clock,
  input  logic        Resetn,
  regfile_n_if.slave  bus
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;

  logic [WIDTH-1:0] rd_data_a_q;
  logic [WIDTH-1:0] rd_data_a_d;
  logic             rd_valid_a_q;
  logic             rd_valid_a_d;
  logic [WIDTH-1:0] rd_data_b_q;
  logic [WIDTH-1:0] rd_data_b_d;
  logic             rd_valid_b_q;
  logic             rd_valid_b_d;

  logic             wr_ok;
  logic [WIDTH-1:0] mux_a;
  logic             mux_va;
  logic [WIDTH-1:0] mux_b;
  logic             mux_vb;

  // Accepted write: strobe high and address maps to a real entry
  always_comb begin
    wr_ok = bus.WrEn && (32'(bus.WrAddr) < 32'(DEPTH));
  end

  // Read muxes; unmatched (out-of-range) addresses fall through to zero
  always_comb begin
    mux_a  = '0;
    mux_va = 1'b0;
    mux_b  = '0;
    mux_vb = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (AW'(i) == bus.RdAddrA) begin
        mux_a  = mem_q[i];
        mux_va = valid_q[i];
      end
      if (AW'(i) == bus.RdAddrB) begin
        mux_b  = mem_q[i];
        mux_vb = valid_q[i];
      end
    end
`ifdef REGFILE_N_BYPASS_EN
    if (wr_ok && (bus.RdAddrA == bus.WrAddr)) begin
      mux_a  = bus.WrData;
      mux_va = 1'b1;
    end
    if (wr_ok && (bus.RdAddrB == bus.WrAddr)) begin
      mux_b  = bus.WrData;
      mux_vb = 1'b1;
    end
`endif
  end

  // Next state: clear-all wins over the write and the read capture
  always_comb begin
    mem_d        = mem_q;
    valid_d      = valid_q;
    rd_data_a_d  = mux_a;
    rd_valid_a_d = mux_va;
    rd_data_b_d  = mux_b;
    rd_valid_b_d = mux_vb;
    if (bus.ClrAll) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = '0;
      end
      valid_d      = '0;
      rd_data_a_d  = '0;
      rd_valid_a_d = 1'b0;
      rd_data_b_d  = '0;
      rd_valid_b_d = 1'b0;
    end else if (wr_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (AW'(i) == bus.WrAddr) begin
          mem_d[i]   = bus.WrData;
          valid_d[i] = 1'b1;
        end
      end
    end
  end

  // Entry storage and valid flags
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      valid_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      valid_q <= valid_d;
    end
  end

  // Registered read outputs
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      rd_data_a_q  <= '0;
      rd_valid_a_q <= 1'b0;
      rd_data_b_q  <= '0;
      rd_valid_b_q <= 1'b0;
    end else begin
      rd_data_a_q  <= rd_data_a_d;
      rd_valid_a_q <= rd_valid_a_d;
      rd_data_b_q  <= rd_data_b_d;
      rd_valid_b_q <= rd_valid_b_d;
    end
  end

  assign bus.RdDataA  = rd_data_a_q;
  assign bus.RdValidA = rd_valid_a_q;
  assign bus.RdDataB  = rd_data_b_q;
  assign bus.RdValidB = rd_valid_b_q;
  assign bus.Valid    = valid_q;

endmodule

// File: tb/tb_regfile_n.sv
// Bench for regfile_n: DEPTH=4 and DEPTH=3 instances share one stimulus
// stream and are checked every cycle against an array-based model.
module tb_regfile_n;

  logic Clock;
  logic Resetn;
  logic       clr_all;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] rd_addr_a;
  logic [1:0] rd_addr_b;

  int n_chk;
  int n_fail;

  regfile_n_if #(.WIDTH(8), .DEPTH(4), .AW(2)) bus0 ();
  regfile_n_if #(.WIDTH(8), .DEPTH(3), .AW(2)) bus1 ();

  assign bus0.ClrAll  = clr_all;
  assign bus0.WrEn    = wr_en;
  assign bus0.WrAddr  = wr_addr;
  assign bus0.WrData  = wr_data;
  assign bus0.RdAddrA = rd_addr_a;
  assign bus0.RdAddrB = rd_addr_b;
  assign bus1.ClrAll  = clr_all;
  assign bus1.WrEn    = wr_en;
  assign bus1.WrAddr  = wr_addr;
  assign bus1.WrData  = wr_data;
  assign bus1.RdAddrA = rd_addr_a;
  assign bus1.RdAddrB = rd_addr_b;

  regfile_n #(.WIDTH(8), .DEPTH(4), .AW(2)) u0 (
    .Clock (Clock),
    .Resetn(Resetn),
    .bus   (bus0)
  );

  regfile_n #(.WIDTH(8), .DEPTH(3), .AW(2)) u1 (
    .Clock (Clock),
    .Resetn(Resetn),
    .bus   (bus1)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Behavioural model: index 0 = DEPTH 4 instance, 1 = DEPTH 3 instance
  int         dep [2];
  logic [7:0] m_mem [2][4];
  logic       m_vld [2][4];
  logic [7:0] m_rda [2];
  logic       m_rva [2];
  logic [7:0] m_rdb [2];
  logic       m_rvb [2];
  bit         bypass;

  initial begin
    dep[0] = 4;
    dep[1] = 3;
`ifdef REGFILE_N_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif
  end

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        m_mem[d][i] = 8'h00;
        m_vld[d][i] = 1'b0;
      end
      m_rda[d] = 8'h00;
      m_rva[d] = 1'b0;
      m_rdb[d] = 8'h00;
      m_rvb[d] = 1'b0;
    end
  endtask

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      model_clear();
    end else if (clr_all) begin
      model_clear();
    end else begin
      for (int d = 0; d < 2; d++) begin
        int a, b, w;
        bit wok;
        a   = int'(rd_addr_a);
        b   = int'(rd_addr_b);
        w   = int'(wr_addr);
        wok = wr_en && (w < dep[d]);
        m_rda[d] = (a < dep[d]) ? m_mem[d][a] : 8'h00;
        m_rva[d] = (a < dep[d]) ? m_vld[d][a] : 1'b0;
        m_rdb[d] = (b < dep[d]) ? m_mem[d][b] : 8'h00;
        m_rvb[d] = (b < dep[d]) ? m_vld[d][b] : 1'b0;
        if (bypass && wok && a == w) begin
          m_rda[d] = wr_data;
          m_rva[d] = 1'b1;
        end
        if (bypass && wok && b == w) begin
          m_rdb[d] = wr_data;
          m_rvb[d] = 1'b1;
        end
        if (wok) begin
          m_mem[d][w] = wr_data;
          m_vld[d][w] = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge Clock) begin
    logic [3:0] ev0;
    logic [2:0] ev1;
    for (int i = 0; i < 4; i++) ev0[i] = m_vld[0][i];
    for (int i = 0; i < 3; i++) ev1[i] = m_vld[1][i];
    chk("d4_rda", 32'(bus0.RdDataA), 32'(m_rda[0]));
    chk("d4_rva", 32'(bus0.RdValidA), 32'(m_rva[0]));
    chk("d4_rdb", 32'(bus0.RdDataB), 32'(m_rdb[0]));
    chk("d4_rvb", 32'(bus0.RdValidB), 32'(m_rvb[0]));
    chk("d4_valid", 32'(bus0.Valid), 32'(ev0));
    chk("d3_rda", 32'(bus1.RdDataA), 32'(m_rda[1]));
    chk("d3_rva", 32'(bus1.RdValidA), 32'(m_rva[1]));
    chk("d3_rdb", 32'(bus1.RdDataB), 32'(m_rdb[1]));
    chk("d3_rvb", 32'(bus1.RdValidB), 32'(m_rvb[1]));
    chk("d3_valid", 32'(bus1.Valid), 32'(ev1));
  end

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    logic [7:0] exp_col;
    n_chk     = 0;
    n_fail    = 0;
    Resetn    = 1'b0;
    clr_all   = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = 2'd0;
    wr_data   = 8'h00;
    rd_addr_a = 2'd0;
    rd_addr_b = 2'd0;
    repeat (2) @(posedge Clock);
    #1;
    Resetn = 1'b1;
    chk("rst_rda", 32'(bus0.RdDataA), 32'h0);
    chk("rst_valid", 32'(bus0.Valid), 32'h0);

    // write entry2, then read it on A while B reads unwritten entry0
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'h3C;
    cyc();
    wr_en = 1'b0; rd_addr_a = 2'd2; rd_addr_b = 2'd0;
    cyc();
    chk("wr_rd_a", 32'(bus0.RdDataA), 32'h3C);
    chk("wr_rd_va", 32'(bus0.RdValidA), 32'h1);
    chk("wr_rd_b", 32'(bus0.RdDataB), 32'h0);
    chk("wr_rd_vb", 32'(bus0.RdValidB), 32'h0);

    // same-cycle write/read collision on entry3
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'h11;
    cyc();
    wr_data = 8'h5A; rd_addr_a = 2'd3;
    cyc();
    exp_col = bypass ? 8'h5A : 8'h11;
    chk("coll_rda", 32'(bus0.RdDataA), 32'(exp_col));
    chk("coll_rva", 32'(bus0.RdValidA), 32'h1);
    wr_en = 1'b0;
    cyc();
    chk("coll_next", 32'(bus0.RdDataA), 32'h5A);

    // clear-all beats a simultaneous write
    clr_all = 1'b1; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'hFF;
    rd_addr_a = 2'd2; rd_addr_b = 2'd3;
    cyc();
    chk("clr_valid", 32'(bus0.Valid), 32'h0);
    chk("clr_rda", 32'(bus0.RdDataA), 32'h0);
    chk("clr_rdb", 32'(bus0.RdDataB), 32'h0);
    clr_all = 1'b0; wr_en = 1'b0; rd_addr_a = 2'd0;
    cyc();
    chk("clr_e0", 32'(bus0.RdDataA), 32'h0);
    chk("clr_e0v", 32'(bus0.RdValidA), 32'h0);

    // out-of-range address on the DEPTH=3 instance
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'h77;
    cyc();
    chk("oor_valid", 32'(bus1.Valid), 32'h0);
    wr_en = 1'b0; rd_addr_a = 2'd3;
    cyc();
    chk("oor_rda", 32'(bus1.RdDataA), 32'h0);
    chk("oor_rva", 32'(bus1.RdValidA), 32'h0);

    // asynchronous reset between clock edges
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'hA5;
    cyc();
    wr_en = 1'b0; rd_addr_a = 2'd1; rd_addr_b = 2'd1;
    cyc();
    chk("pre_rst_a", 32'(bus0.RdDataA), 32'hA5);
    Resetn = 1'b0;
    #1;
    chk("arst_rda", 32'(bus0.RdDataA), 32'h0);
    chk("arst_rdb", 32'(bus0.RdDataB), 32'h0);
    chk("arst_valid", 32'(bus0.Valid), 32'h0);
    #1;
    Resetn = 1'b1;

    // randomized traffic, occasional clear and mid-cycle reset pulses
    for (int n = 0; n < 600; n++) begin
      clr_all   = ($urandom_range(0, 19) == 0);
      wr_en     = ($urandom_range(0, 1) == 1);
      wr_addr   = 2'($urandom_range(0, 3));
      wr_data   = 8'($urandom);
      rd_addr_a = 2'($urandom_range(0, 3));
      rd_addr_b = ($urandom_range(0, 3) == 0) ? rd_addr_a
                                              : 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) begin
        Resetn = 1'b0;
        #2;
        Resetn = 1'b1;
      end
      cyc();
    end

    clr_all = 1'b0;
    wr_en   = 1'b0;
    @(negedge Clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_n.md
REGFILE_N -- requirements
Module: regfile_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per entry (1..32).
REQ-002 SHALL have parameter DEPTH, default 4, number of entries (2..16, need not be a power of two).
REQ-003 SHALL have parameter AW, default 2, address width, ceil(log2(DEPTH)).
REQ-004 SHALL have port Clock  input  1  rising-edge clock.
REQ-005 SHALL have port Resetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port ClrAll  input  1  synchronous clear of all entries.
REQ-007 SHALL have port WrEn  input  1  write strobe.
REQ-008 SHALL have port WrAddr  input  AW  write address.
REQ-009 SHALL have port WrData  input  WIDTH  write data.
REQ-010 SHALL have port RdAddrA  input  AW  read address, port A.
REQ-011 SHALL have port RdDataA  output  WIDTH  registered read data, port A.
REQ-012 SHALL have port RdValidA  output  1  registered valid flag of entry read on port A.
REQ-013 SHALL have port RdAddrB  input  AW  read address, port B.
REQ-014 SHALL have port RdDataB  output  WIDTH  registered read data, port B.
REQ-015 SHALL have port RdValidB  output  1  registered valid flag of entry read on port B.
REQ-016 SHALL have port Valid  output  DEPTH  per-entry written flag, bit i = entry i.

Function
REQ-017 SHALL hold DEPTH entries of WIDTH bits plus one Valid bit per entry.
REQ-018 SHALL, on rising Clock with WrEn=1, ClrAll=0, WrAddr<DEPTH: entry[WrAddr]<=WrData, Valid[WrAddr]<=1.
REQ-019 SHALL ignore writes with WrAddr>=DEPTH (no entry or Valid bit changes).
REQ-020 SHALL, on rising Clock with ClrAll=1: all entries <=0, all Valid <=0, RdDataA/B <=0, RdValidA/B <=0; ClrAll takes priority over WrEn.
REQ-021 SHALL, on every rising Clock with ClrAll=0, load RdDataA<=entry[RdAddrA] and RdValidA<=Valid[RdAddrA] using pre-edge contents (1-cycle read latency); port B identically.
REQ-022 SHALL, for read address >=DEPTH, load RdData<=0 and RdValid<=0.
REQ-023 SHALL allow both read ports to address the same entry in one cycle, both returning identical data.
REQ-024 SHALL allow a write and two reads in the same cycle with no stall; same-address collision resolved per REQ-031/032.
REQ-025 SHALL keep entries with WrEn=0 unchanged indefinitely (hold).
REQ-026 SHALL drive Valid directly from the Valid flops (no output register delay).

Reset
REQ-027 SHALL, while Resetn=0, immediately force all entries, Valid, RdDataA/B, RdValidA/B to 0, independent of Clock.
REQ-028 SHALL, on Resetn assertion mid-operation, abandon any in-flight write; no partial data is retained.
REQ-029 SHALL resume normal operation on the first rising Clock after Resetn returns to 1.
REQ-030 SHALL give Resetn priority over ClrAll and WrEn.

Configuration
REQ-031 SHALL, with macro REGFILE_N_BYPASS_EN defined, forward WrData (and valid=1) to a read port whose address equals WrAddr in a cycle with an accepted write, giving write-to-read latency of 1 cycle.
REQ-032 SHALL, without REGFILE_N_BYPASS_EN, return the pre-write entry contents and Valid on such a collision; new data is visible on the following read.

Verification
REQ-033 SHALL verify reset: pulse Resetn=0 between clocks after writing entry1=0xA5 -> RdDataA/B=0x00, Valid=4'b0000 without a clock edge.
REQ-034 SHALL verify write/read: write entry2=0x3C, next cycle RdAddrA=2 -> RdDataA=0x3C, RdValidA=1 one clock later; RdAddrB=0 -> RdDataB=0x00, RdValidB=0.
REQ-035 SHALL verify collision: WrEn=1 WrAddr=3 WrData=0x5A, RdAddrA=3 same cycle, entry3 previously 0x11 -> RdDataA=0x5A with REGFILE_N_BYPASS_EN, 0x11 without.
REQ-036 SHALL verify ClrAll priority: ClrAll=1 with WrEn=1 WrAddr=0 WrData=0xFF -> entry0=0x00, Valid=4'b0000, RdDataA/B=0x00.
REQ-037 SHALL verify out-of-range with DEPTH=3: write WrAddr=3 WrData=0x77 -> Valid=3'b000; read RdAddrA=3 -> RdDataA=0x00, RdValidA=0.
